// File: rtl/alu_pkg.sv
// Shared constants, command encodings and FSM states for the ALU core.
// Also holds the operand-need classification used by the control FSM.
package alu_pkg;

  localparam int OP_WIDTH_DEF   = 8;
  localparam int CMD_WIDTH_DEF  = 4;
  localparam int TIMEOUT_CYCLES = 16;

  typedef enum logic [CMD_WIDTH_DEF-1:0] {
    A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN, A_INC_A, A_DEC_A, A_INC_B, A_DEC_B,
    A_CMP, A_INC_MUL, A_SHL_MUL
  } arith_cmd_e;

  typedef enum logic [CMD_WIDTH_DEF-1:0] {
    L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR, L_NOT_A, L_NOT_B,
    L_SHR1_A, L_SHL1_A, L_SHR1_B, L_SHL1_B, L_ROL_A_B, L_ROR_A_B
  } logic_cmd_e;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_MUL} alu_state_e;

  // Returns {need_b, need_a}; undecoded commands fall into the two-operand class.
  function automatic logic [1:0] op_need(input logic mode, input logic [CMD_WIDTH_DEF-1:0] cmd);
    op_need = 2'b11;
    if (mode) begin
      if (cmd == A_INC_A || cmd == A_DEC_A) op_need = 2'b01;
      else if (cmd == A_INC_B || cmd == A_DEC_B) op_need = 2'b10;
    end else begin
      if (cmd == L_NOT_A || cmd == L_SHR1_A || cmd == L_SHL1_A) op_need = 2'b01;
      else if (cmd == L_NOT_B || cmd == L_SHR1_B || cmd == L_SHL1_B) op_need = 2'b10;
    end
  endfunction

  function automatic logic is_mul(input logic mode, input logic [CMD_WIDTH_DEF-1:0] cmd);
    is_mul = mode && (cmd == A_INC_MUL || cmd == A_SHL_MUL);
  endfunction

endpackage

// File: rtl/alu_exec.sv
// Purely combinational ALU datapath: one operation per call, result plus flags.
// Error results (undecoded command, bad rotate amount) force RES to zero.
module alu_exec
  import alu_pkg::*;
#(
  parameter int OP_WIDTH  = OP_WIDTH_DEF,
  parameter int CMD_WIDTH = CMD_WIDTH_DEF
) (
  input  logic [OP_WIDTH-1:0]  opa,
  input  logic [OP_WIDTH-1:0]  opb,
  input  logic [CMD_WIDTH-1:0] cmd,
  input  logic                 mode,
  input  logic                 cin,
  output logic [OP_WIDTH:0]    res,
  output logic                 cout,
  output logic                 oflow,
  output logic                 err,
  output logic                 g,
  output logic                 l,
  output logic                 e
);

  localparam int RW = OP_WIDTH + 1;
  localparam int SH = $clog2(OP_WIDTH);

  logic [RW-1:0]       a_x, b_x, one_x, cin_x;
  logic [2*RW-1:0]     prod_inc, prod_shl;
  logic [SH-1:0]       sh;
  logic [OP_WIDTH-1:0] rol_a, ror_a, lres;

  assign a_x   = {1'b0, opa};
  assign b_x   = {1'b0, opb};
  assign one_x = {{OP_WIDTH{1'b0}}, 1'b1};
  assign cin_x = {{OP_WIDTH{1'b0}}, cin};

  assign prod_inc = {{RW{1'b0}}, a_x + one_x} * {{RW{1'b0}}, b_x + one_x};
  assign prod_shl = {{RW{1'b0}}, opa, 1'b0} * {{RW{1'b0}}, b_x};

  assign sh    = opb[SH-1:0];
  assign rol_a = (opa << sh) | (opa >> (OP_WIDTH - int'(sh)));
  assign ror_a = (opa >> sh) | (opa << (OP_WIDTH - int'(sh)));

  always_comb begin
    res   = '0;
    cout  = 1'b0;
    oflow = 1'b0;
    err   = 1'b0;
    g     = 1'b0;
    l     = 1'b0;
    e     = 1'b0;
    lres  = '0;
    if (mode) begin
      case (arith_cmd_e'(cmd))
        A_ADD:     begin res = a_x + b_x;         cout = res[OP_WIDTH]; end
        A_SUB:     begin res = a_x - b_x;         oflow = (a_x < b_x); end
        A_ADD_CIN: begin res = a_x + b_x + cin_x; cout = res[OP_WIDTH]; end
        A_SUB_CIN: begin res = a_x - b_x - cin_x; oflow = (a_x < (b_x + cin_x)); end
        A_INC_A:   begin res = a_x + one_x;       cout = res[OP_WIDTH]; end
        A_DEC_A:   begin res = a_x - one_x;       oflow = (opa == '0); end
        A_INC_B:   begin res = b_x + one_x;       cout = res[OP_WIDTH]; end
        A_DEC_B:   begin res = b_x - one_x;       oflow = (opb == '0); end
        A_CMP: begin
          g = (opa > opb);
          l = (opa < opb);
          e = (opa == opb);
        end
        A_INC_MUL: begin res = prod_inc[RW-1:0]; oflow = |prod_inc[2*RW-1:RW]; end
        A_SHL_MUL: begin res = prod_shl[RW-1:0]; oflow = |prod_shl[2*RW-1:RW]; end
        default:   err = 1'b1;
      endcase
    end else begin
      case (logic_cmd_e'(cmd))
        L_AND:     lres = opa & opb;
        L_NAND:    lres = ~(opa & opb);
        L_OR:      lres = opa | opb;
        L_NOR:     lres = ~(opa | opb);
        L_XOR:     lres = opa ^ opb;
        L_XNOR:    lres = ~(opa ^ opb);
        L_NOT_A:   lres = ~opa;
        L_NOT_B:   lres = ~opb;
        L_SHR1_A:  lres = {1'b0, opa[OP_WIDTH-1:1]};
        L_SHL1_A:  lres = {opa[OP_WIDTH-2:0], 1'b0};
        L_SHR1_B:  lres = {1'b0, opb[OP_WIDTH-1:1]};
        L_SHL1_B:  lres = {opb[OP_WIDTH-2:0], 1'b0};
        // Rotate amounts beyond the operand width are rejected, not wrapped.
        L_ROL_A_B: if (|opb[OP_WIDTH-1:SH]) err = 1'b1; else lres = rol_a;
        L_ROR_A_B: if (|opb[OP_WIDTH-1:SH]) err = 1'b1; else lres = ror_a;
        default:   err = 1'b1;
      endcase
      res = {1'b0, lres};
    end
  end

endmodule

// File: rtl/alu_core.sv
// ALU control: operand gathering FSM (IDLE/WAIT/MUL), operand latches, WAIT timeout
// counter and registered outputs around the combinational alu_exec datapath.
module alu_core
  import alu_pkg::*;
#(
  parameter int OP_WIDTH  = OP_WIDTH_DEF,
  parameter int CMD_WIDTH = CMD_WIDTH_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CE,
  input  logic                 MODE,
  input  logic [CMD_WIDTH-1:0] CMD,
  input  logic [1:0]           INP_VALID,
  input  logic [OP_WIDTH-1:0]  OPA,
  input  logic [OP_WIDTH-1:0]  OPB,
  input  logic                 CIN,
  output logic [OP_WIDTH:0]    RES,
  output logic                 COUT,
  output logic                 OFLOW,
  output logic                 ERR,
  output logic                 G,
  output logic                 L,
  output logic                 E,
  output alu_state_e           dbg_state
);

  // Handshake: INP_VALID bits qualify OPA/OPB on the edge they are sampled with CE
  // high; there is no back-pressure, a completing operation updates all outputs.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  alu_state_e state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [CMD_WIDTH-1:0] cmd_q, ex_cmd;
  logic                 mode_q, cin_q, ex_mode, ex_cin;
  logic [OP_WIDTH-1:0]  opa_q, opb_q, ex_opa, ex_opb;
  logic [1:0]           have_q, need;
  logic                 fire, latch, tmo, cnt_clr, cnt_inc, arrive;
  logic [OP_WIDTH:0]    x_res;
  logic                 x_cout, x_oflow, x_err, x_g, x_l, x_e;

  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    ex_cmd  = CMD;
    ex_mode = MODE;
    ex_cin  = CIN;
    ex_opa  = OPA;
    ex_opb  = OPB;
    fire    = 1'b0;
    latch   = 1'b0;
    tmo     = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    arrive  = 1'b0;
    need    = op_need(MODE, CMD);
    case (state_q)
      ST_IDLE: begin
        if (INP_VALID != 2'b00 && (INP_VALID & need) == need) begin
          if (is_mul(MODE, CMD)) begin
            latch   = 1'b1;
            state_d = ST_MUL;
          end else begin
            fire = 1'b1;
          end
        end else if (need == 2'b11 && INP_VALID != 2'b00) begin
          latch   = 1'b1;
          cnt_clr = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        ex_cmd  = cmd_q;
        ex_mode = mode_q;
        ex_cin  = cin_q;
        ex_opa  = INP_VALID[0] ? OPA : opa_q;
        ex_opb  = INP_VALID[1] ? OPB : opb_q;
        arrive  = (INP_VALID == 2'b11) || ((INP_VALID & ~have_q) != 2'b00);
        if (arrive) begin
          if (is_mul(mode_q, cmd_q)) begin
            latch   = 1'b1;
            state_d = ST_MUL;
          end else begin
            fire    = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          tmo     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_MUL: begin
        ex_cmd  = cmd_q;
        ex_mode = mode_q;
        ex_cin  = cin_q;
        ex_opa  = opa_q;
        ex_opb  = opb_q;
        fire    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  alu_exec #(.OP_WIDTH(OP_WIDTH), .CMD_WIDTH(CMD_WIDTH)) u_exec (
    .opa(ex_opa), .opb(ex_opb), .cmd(ex_cmd), .mode(ex_mode), .cin(ex_cin),
    .res(x_res), .cout(x_cout), .oflow(x_oflow), .err(x_err), .g(x_g), .l(x_l), .e(x_e)
  );

  always_ff @(posedge CLK) begin
    if (!RST) state_q <= ST_IDLE;
    else if (CE) state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q  <= '0;
      cmd_q  <= '0;
      mode_q <= 1'b0;
      cin_q  <= 1'b0;
      opa_q  <= '0;
      opb_q  <= '0;
      have_q <= 2'b00;
      RES    <= '0;
      COUT   <= 1'b0;
      OFLOW  <= 1'b0;
      ERR    <= 1'b0;
      G      <= 1'b0;
      L      <= 1'b0;
      E      <= 1'b0;
    end else if (CE) begin
      if (latch) begin
        cmd_q  <= ex_cmd;
        mode_q <= ex_mode;
        cin_q  <= ex_cin;
        opa_q  <= ex_opa;
        opb_q  <= ex_opb;
        have_q <= INP_VALID;
      end
      if (cnt_clr) cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
      if (fire) begin
        RES   <= x_res;
        COUT  <= x_cout;
        OFLOW <= x_oflow;
        ERR   <= x_err;
        G     <= x_g;
        L     <= x_l;
        E     <= x_e;
      end else if (tmo) begin
        RES   <= '0;
        COUT  <= 1'b0;
        OFLOW <= 1'b0;
        ERR   <= 1'b1;
        G     <= 1'b0;
        L     <= 1'b0;
        E     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Bench for alu_core: directed cases with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the ALU.
module tb_alu_core;
  import alu_pkg::*;

  logic       CLK, RST, CE, MODE, CIN;
  logic [3:0] CMD;
  logic [1:0] INP_VALID;
  logic [7:0] OPA, OPB;
  logic [8:0] RES;
  logic       COUT, OFLOW, ERR, G, L, E;
  alu_state_e dbg_state;

  typedef struct packed {
    logic [8:0] res;
    logic cout, oflow, err, g, l, e;
  } outs_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: expected outputs plus the pending transaction, if any.
  outs_t m_out = '0;
  bit    m_wait = 0, m_mul = 0;
  int    m_age = 0, m_have = 0;
  bit    q_mode = 0, q_cin = 0;
  int    q_cmd = 0, q_a = 0, q_b = 0;

  alu_core dut (
    .CLK(CLK), .RST(RST), .CE(CE), .MODE(MODE), .CMD(CMD), .INP_VALID(INP_VALID),
    .OPA(OPA), .OPB(OPB), .CIN(CIN), .RES(RES), .COUT(COUT), .OFLOW(OFLOW),
    .ERR(ERR), .G(G), .L(L), .E(E), .dbg_state(dbg_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic outs_t calc(bit mode, int cmd, int a, int b, bit cin);
    outs_t  o;
    int     r;
    longint p;
    o = '0;
    r = 0;
    if (mode) begin
      case (cmd)
        0:  begin r = a + b;       o.res = r[8:0]; o.cout = (r >= 256); end
        1:  begin r = a - b;       o.res = r[8:0]; o.oflow = (a < b); end
        2:  begin r = a + b + cin; o.res = r[8:0]; o.cout = (r >= 256); end
        3:  begin r = a - b - cin; o.res = r[8:0]; o.oflow = (a < b + cin); end
        4:  begin r = a + 1;       o.res = r[8:0]; o.cout = (r >= 256); end
        5:  begin r = a - 1;       o.res = r[8:0]; o.oflow = (a == 0); end
        6:  begin r = b + 1;       o.res = r[8:0]; o.cout = (r >= 256); end
        7:  begin r = b - 1;       o.res = r[8:0]; o.oflow = (b == 0); end
        8:  begin o.g = (a > b); o.l = (a < b); o.e = (a == b); end
        9:  begin p = longint'(a + 1) * longint'(b + 1); o.res = p[8:0]; o.oflow = (p >= 512); end
        10: begin p = longint'(2 * a) * longint'(b);     o.res = p[8:0]; o.oflow = (p >= 512); end
        default: o.err = 1'b1;
      endcase
    end else begin
      case (cmd)
        0:  r = a & b;
        1:  r = 255 - (a & b);
        2:  r = a | b;
        3:  r = 255 - (a | b);
        4:  r = a ^ b;
        5:  r = 255 - (a ^ b);
        6:  r = 255 - a;
        7:  r = 255 - b;
        8:  r = a / 2;
        9:  r = (a * 2) % 256;
        10: r = b / 2;
        11: r = (b * 2) % 256;
        12: if (b > 7) o.err = 1'b1;
            else begin r = a; repeat (b) r = ((r * 2) % 256) + (r / 128); end
        13: if (b > 7) o.err = 1'b1;
            else begin r = a; repeat (b) r = (r / 2) + 128 * (r % 2); end
        default: o.err = 1'b1;
      endcase
      if (!o.err) o.res = r[8:0];
    end
    return o;
  endfunction

  function automatic int need_of(bit mode, int cmd);
    if (mode) begin
      if (cmd == 4 || cmd == 5) return 1;
      if (cmd == 6 || cmd == 7) return 2;
    end else begin
      if (cmd == 6 || cmd == 8 || cmd == 9) return 1;
      if (cmd == 7 || cmd == 10 || cmd == 11) return 2;
    end
    return 3;
  endfunction

  function automatic void finish_op(bit mode, int cmd, bit cin, int a, int b);
    m_wait = 0;
    if (mode && (cmd == 9 || cmd == 10)) begin
      m_mul = 1; q_mode = mode; q_cmd = cmd; q_cin = cin; q_a = a; q_b = b;
    end else begin
      m_out = calc(mode, cmd, a, b, cin);
    end
  endfunction

  // Advances the model by one rising edge using the inputs that edge will sample.
  function automatic void model_step();
    int iv, need;
    iv = int'(INP_VALID);
    if (!RST) begin
      m_out = '0; m_wait = 0; m_mul = 0; m_age = 0;
    end else if (CE) begin
      if (m_mul) begin
        m_out = calc(q_mode, q_cmd, q_a, q_b, q_cin);
        m_mul = 0;
      end else if (m_wait) begin
        if (iv == 3) finish_op(q_mode, q_cmd, q_cin, int'(OPA), int'(OPB));
        else if (iv != 0 && iv != m_have)
          finish_op(q_mode, q_cmd, q_cin, (m_have == 1) ? q_a : int'(OPA), (m_have == 2) ? q_b : int'(OPB));
        else if (m_age == TIMEOUT_CYCLES - 1) begin
          m_out = '0; m_out.err = 1'b1; m_wait = 0;
        end else m_age++;
      end else begin
        need = need_of(MODE, int'(CMD));
        if (iv != 0 && (iv & need) == need) finish_op(MODE, int'(CMD), CIN, int'(OPA), int'(OPB));
        else if (need == 3 && iv != 0) begin
          m_wait = 1; m_have = iv; m_age = 0;
          q_mode = MODE; q_cmd = int'(CMD); q_cin = CIN; q_a = int'(OPA); q_b = int'(OPB);
        end
      end
    end
  endfunction

  // Compare DUT against the model mid-cycle, then advance the model.
  initial forever begin
    outs_t got;
    @(negedge CLK);
    got = {RES, COUT, OFLOW, ERR, G, L, E};
    n_checks++;
    if (got !== m_out) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t: got res=%h c%b o%b err%b g%b l%b e%b, expected res=%h c%b o%b err%b g%b l%b e%b",
               $time, got.res, got.cout, got.oflow, got.err, got.g, got.l, got.e,
               m_out.res, m_out.cout, m_out.oflow, m_out.err, m_out.g, m_out.l, m_out.e);
    end
    model_step();
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic drive(input bit mode, input int cmd, input int iv, input int a, input int b, input bit cin = 0);
    MODE = mode; CMD = cmd[3:0]; INP_VALID = iv[1:0]; OPA = a[7:0]; OPB = b[7:0]; CIN = cin;
  endtask

  initial begin
    int r;
    RST = 1'b0; CE = 1'b1;
    drive(1, 0, 0, 0, 0);
    tick(2);
    chk("reset_res", RES, 0);
    chk("reset_flags", {COUT, OFLOW, ERR, G, L, E}, 0);
    RST = 1'b1;

    drive(1, 0, 3, 'hFF, 'h01); tick();
    chk("add_res", RES, 'h100); chk("add_cout", COUT, 1);
    drive(1, 1, 3, 'h05, 'h0A); tick();
    chk("sub_res", RES, 'h1FB); chk("sub_oflow", OFLOW, 1);
    drive(1, 8, 3, 'h33, 'h33); tick();
    chk("cmp_gle", {G, L, E, RES}, {3'b001, 9'h000});

    drive(1, 9, 3, 'h03, 'h04); tick();
    chk("mul_state", 32'(dbg_state), 32'(ST_MUL));
    chk("mul_hold", {RES, E}, {9'h000, 1'b1});
    drive(1, 0, 0, 0, 0); tick();
    chk("incmul_res", RES, 'h014);
    drive(1, 9, 3, 'hFF, 'hFF); tick(); drive(1, 0, 0, 0, 0); tick();
    chk("incmul_ovf", {RES, OFLOW}, {9'h000, 1'b1});

    drive(1, 0, 1, 'h0A, 0); tick();
    drive(1, 1, 0, 0, 0, 1); tick(4);
    drive(1, 1, 2, 0, 'h14, 1); tick();
    chk("split_add", {RES, ERR}, {9'h01E, 1'b0});

    drive(1, 0, 1, 'h22, 0); tick();
    drive(1, 0, 0, 0, 0); tick(15);
    chk("wait_no_tmo", ERR, 0);
    tick();
    chk("wait_tmo", {RES, ERR}, {9'h000, 1'b1});

    drive(0, 12, 3, 'h81, 'h01); tick();
    chk("rol_res", {RES, ERR}, {9'h003, 1'b0});
    drive(0, 12, 3, 'h81, 'h10); tick();
    chk("rol_err", {RES, ERR}, {9'h000, 1'b1});

    drive(1, 9, 3, 'h03, 'h04); tick();
    CE = 1'b0; drive(1, 0, 3, 'hFF, 'hFF); tick(3);
    chk("ce_freeze", {RES, ERR}, {9'h000, 1'b1});
    CE = 1'b1; drive(1, 0, 0, 0, 0); tick();
    chk("ce_mul_late", RES, 'h014);

    drive(1, 0, 3, 'hFF, 'h01); tick();
    drive(1, 0, 1, 'h10, 0); tick();
    RST = 1'b0; drive(1, 0, 0, 0, 0); tick();
    chk("rst_wait", {RES, COUT, OFLOW, ERR, G, L, E}, 0);
    RST = 1'b1; drive(1, 0, 2, 0, 'h14); tick();
    chk("rst_wait_nolate", RES, 0);
    RST = 1'b0; drive(1, 0, 0, 0, 0); tick(); RST = 1'b1;

    drive(1, 0, 3, 'hFF, 'h01); tick();
    drive(1, 9, 3, 'h03, 'h04); tick();
    RST = 1'b0; drive(1, 0, 0, 0, 0); tick();
    chk("rst_mul", {RES, COUT, OFLOW, ERR, G, L, E}, 0);
    RST = 1'b1; tick(2);
    chk("rst_mul_nolate", RES, 0);

    drive(1, 15, 3, 'h12, 'h34); tick();
    chk("undecoded", {RES, ERR}, {9'h000, 1'b1});
    drive(1, 4, 1, 'hFF, 0); tick();
    chk("inc_a", {RES, COUT}, {9'h100, 1'b1});
    drive(1, 7, 2, 0, 'h00); tick();
    chk("dec_b", {RES, OFLOW}, {9'h1FF, 1'b1});

    for (int i = 0; i < 4000; i++) begin
      RST  = ($urandom_range(0, 63) != 0);
      CE   = ($urandom_range(0, 7) != 0);
      r    = $urandom_range(0, 5);
      MODE = $urandom_range(0, 1);
      CMD  = 4'($urandom_range(0, 15));
      INP_VALID = (r < 3) ? 2'b00 : 2'(r - 2);
      OPA  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      OPB  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom_range(0, 255));
      CIN  = $urandom_range(0, 1);
      tick();
    end

    RST = 1'b1; CE = 1'b1; drive(1, 0, 0, 0, 0);
    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
